booth_multiplier: RTL and testbench

Sequential radix-2 Booth multiplier for two's-complement signed operands. It produces a 2·WIDTH-bit signed product after a fixed number of clock cycles and uses a start/done handshake. It is a datapath leaf that sits behind any controller that needs signed multiplication without a combinational array multiplier.

---
 rtl/booth_pkg.sv | 18 +
 rtl/booth_multiplier_if.sv | 25 ++
 rtl/booth_multiplier_step.sv | 30 +++
 rtl/booth_multiplier.sv | 108 ++++++++++
 tb/tb_booth_multiplier.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W = $clog2(DEFAULT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    // Iteration counter must hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/booth_multiplier_if.sv
// Start/done handshake and operand/product bus of the Booth multiplier.
interface booth_multiplier_if
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   c;
    logic                 done;
    logic                 busy;

    modport master (
        output start, a, b,
        input  c, done, busy
    );

    modport slave (
        input  start, a, b,
        output c, done, busy
    );

endinterface

// File: rtl/booth_multiplier_step.sv
// One Booth iteration: conditional add/subtract of M, then arithmetic right shift of {A,Q,q_1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH:0]   m,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_1_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc;
        case ({q[0], q_1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        acc_next = {sum[WIDTH], sum[WIDTH:1]};
        q_next   = {sum[0], q[WIDTH-1:1]};
        q_1_next = q[0];
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier top: FSM, operand registers and handshake.
// Optional BOOTH_ZERO_SKIP_EN: a zero operand jumps straight to FINISH with a zero product.
module booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic               clk,
    input logic               rst_n,
    booth_multiplier_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t state, state_next;

    logic [WIDTH:0]     acc, m, acc_step;
    logic [WIDTH-1:0]   q, q_step;
    logic               q_1, q_1_step;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] c_reg;
    logic               done_reg;
    logic               zero_op;
    logic               accept;

`ifdef BOOTH_ZERO_SKIP_EN
    assign zero_op = (bus.a == '0) || (bus.b == '0);
`else
    assign zero_op = 1'b0;
`endif

    assign accept = (state == IDLE) && bus.start;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .m        (m),
        .q        (q),
        .q_1      (q_1),
        .acc_next (acc_step),
        .q_next   (q_step),
        .q_1_next (q_1_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = zero_op ? FINISH : RUN;
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Q is forced to zero on a skipped operand so FINISH assembles a zero product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
        end else if (accept) begin
            acc   <= '0;
            m     <= {bus.a[WIDTH-1], bus.a};
            q     <= zero_op ? '0 : bus.b;
            q_1   <= 1'b0;
            count <= CW'(WIDTH);
        end else if (state == RUN) begin
            acc   <= acc_step;
            q     <= q_step;
            q_1   <= q_1_step;
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_reg    <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= (state == FINISH);
            if (state == FINISH) begin
                c_reg <= {acc[WIDTH-1:0], q};
            end
        end
    end

    assign bus.c    = c_reg;
    assign bus.done = done_reg;
    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed self-checking bench for booth_multiplier (WIDTH=8) with hand-computed products.
module tb_booth_multiplier;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;

    int checks   = 0;
    int failures = 0;
    logic [15:0] last_c = '0;

    always #5 clk = ~clk;

    booth_multiplier_if #(.WIDTH(WIDTH)) bus ();

    booth_multiplier #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int expLatency(input logic [7:0] av, input logic [7:0] bv);
`ifdef BOOTH_ZERO_SKIP_EN
        if (av == 8'h00 || bv == 8'h00) return 1;
`endif
        return WIDTH + 1;
    endfunction

    // Counts edges after the start edge; lat stays 0 if done never arrives in the budget.
    task automatic waitDone(input int first, output int lat);
        lat = 0;
        for (int i = first; i < first + WIDTH + 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                 input logic [15:0] expc, input string tag);
        int lat;
        @(negedge clk);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
        checkOutput({tag, "_hold"}, 32'(bus.c), 32'(last_c));
        waitDone(1, lat);
        checkOutput({tag, "_lat"}, 32'(lat), 32'(expLatency(av, bv)));
        checkOutput({tag, "_c"}, 32'(bus.c), 32'(expc));
        checkOutput({tag, "_busylow"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_pulse"}, 32'(bus.done), 32'd0);
        last_c = expc;
    endtask

    logic [7:0]  b2b_a [3] = '{8'hF0, 8'h80, 8'h08};
    logic [7:0]  b2b_b [3] = '{8'hF0, 8'h7F, 8'hBF};
    logic [15:0] b2b_c [3] = '{16'h0100, 16'hC080, 16'hFDF8};

    initial begin
        int lat;
        int ndone;
        int last_done;
        int next_op;
        bit advance;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_c", 32'(bus.c), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'hF0, 8'hF0, 16'h0100, "mix0");
        applyStimulus(8'hB5, 8'h20, 16'hF6A0, "mix1");
        applyStimulus(8'hBA, 8'h23, 16'hF66E, "mix2");
        applyStimulus(8'h08, 8'hBF, 16'hFDF8, "mix3");
        applyStimulus(8'h01, 8'h01, 16'h0001, "pos0");
        applyStimulus(8'h34, 8'h05, 16'h0104, "pos1");
        applyStimulus(8'h11, 8'h1C, 16'h01DC, "pos2");
        applyStimulus(8'h80, 8'h80, 16'h4000, "ext0");
        applyStimulus(8'h80, 8'h7F, 16'hC080, "ext1");
        applyStimulus(8'h7F, 8'h7F, 16'h3F01, "ext2");
        applyStimulus(8'h07, 8'h00, 16'h0000, "zero");

        // Reset asserted in the middle of the fourth cycle of a run.
        applyStimulus(8'h7F, 8'h7F, 16'h3F01, "pre_rst");
        @(negedge clk);
        bus.a     = 8'h34;
        bus.b     = 8'h05;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_c", 32'(bus.c), 32'd0);
        checkOutput("midrst_done", 32'(bus.done), 32'd0);
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        last_c = '0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h11, 8'h1C, 16'h01DC, "postrst");

        // A start pulse while busy must not disturb the running product.
        @(negedge clk);
        bus.a     = 8'hBA;
        bus.b     = 8'h23;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.a     = 8'h7F;
        bus.b     = 8'h7F;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("ign_hold", 32'(bus.c), 32'(last_c));
        waitDone(4, lat);
        checkOutput("ign_lat", 32'(lat), 32'(WIDTH + 1));
        checkOutput("ign_c", 32'(bus.c), 32'hF66E);
        last_c = 16'hF66E;
        ndone = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        checkOutput("ign_extra", 32'(ndone), 32'd0);
        checkOutput("ign_c_keep", 32'(bus.c), 32'hF66E);

        // Start held high across three operations.
        @(negedge clk);
        bus.a     = b2b_a[0];
        bus.b     = b2b_b[0];
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.a     = b2b_a[1];
        bus.b     = b2b_b[1];
        ndone     = 0;
        last_done = 0;
        next_op   = 2;
        advance   = 1'b0;
        for (int cyc = 1; cyc <= 4 * (WIDTH + 2); cyc++) begin
            @(posedge clk);
            #1;
            if (advance) begin
                advance = 1'b0;
                if (next_op < 3) begin
                    bus.a = b2b_a[next_op];
                    bus.b = b2b_b[next_op];
                    next_op++;
                end else begin
                    bus.start = 1'b0;
                end
            end
            if (bus.done) begin
                if (ndone < 3) begin
                    checkOutput($sformatf("b2b%0d_c", ndone), 32'(bus.c), 32'(b2b_c[ndone]));
                    checkOutput($sformatf("b2b%0d_gap", ndone), 32'(cyc - last_done),
                                ndone == 0 ? 32'(WIDTH + 1) : 32'(WIDTH + 2));
                end
                last_done = cyc;
                ndone++;
                advance = 1'b1;
            end
        end
        checkOutput("b2b_count", 32'(ndone), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
